mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM pipeline stage, directly downstream of the EX/MEM register.
- Consumes the MEM_* control/data bundle and runs a req/ack handshake to data memory.
- Raises stall_req while an access is outstanding.
- Registers the writeback bundle (WB_*) consumed by the register file write port, so it also acts as the MEM/WB register.

Parameters:
ADDR_W, 32, data-memory byte address width
TIMEOUT, 16, max BUSY cycles before abort (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  reset
MEM_Reg_WriteAddr  in  5  destination register of MEM-stage instruction
MEM_Reg_WriteEn  in  1  instruction writes a register
MEM_AluResult  in  32  ALU result
MEM_Mem2R  in  1  writeback data comes from memory
MEM_DMem_WriteAddr  in  ADDR_W  memory address (load and store)
MEM_DMem_WriteEn  in  1  store
MEM_DMem_ReadEn  in  1  load
MEM_DMem_WriteData  in  32  store data
dmem_req  out  1  access request, registered
dmem_we  out  1  1=write, 0=read, registered
dmem_addr  out  ADDR_W  word-aligned address, registered
dmem_wdata  out  32  store data, registered
dmem_rdata  in  32  read data, valid with dmem_ack
dmem_ack  in  1  access complete, one-cycle pulse
stall_req  out  1  hold PC/IF/ID/EX/EX_MEM, combinational
WB_Reg_WriteAddr  out  5  registered writeback address
WB_Reg_WriteEn  out  1  registered writeback enable
WB_WriteData  out  32  registered writeback data
bus_err  out  1  access aborted, one-cycle pulse

Behaviour:
- Clock and reset: one clock `clk`, posedge. `rst` is asynchronous and active-high.
- Reset values: state=IDLE, all dmem_* outputs 0, WB_* all 0, bus_err 0, timeout counter 0.
- mem_op = MEM_DMem_ReadEn | MEM_DMem_WriteEn. If both are set, the access is a write.
- States: IDLE, BUSY.
- IDLE, mem_op=0:
  - stall_req=0.
  - Next edge loads WB_* from inputs: WB_WriteData=MEM_AluResult; enable and address copied.
  - Non-memory latency is 1 cycle.
- IDLE, mem_op=1:
  - stall_req=1; WB_* load a bubble (all 0).
  - Next edge: state→BUSY, dmem_req=1, dmem_we=MEM_DMem_WriteEn, dmem_addr={addr[ADDR_W-1:2],2'b00}, dmem_wdata=MEM_DMem_WriteData.
  - Inputs stay stable because the upstream stages are stalled.
- BUSY, dmem_ack=0:
  - stall_req=1; dmem_* held; WB_* load a bubble.
- BUSY, dmem_ack=1:
  - stall_req=0 in the same cycle.
  - Next edge: state→IDLE, dmem_req=0.
  - WB_* load the instruction: WB_WriteData = MEM_Mem2R ? dmem_rdata : MEM_AluResult.
  - Minimum memory-op occupancy is 2 cycles (IDLE + BUSY with immediate ack).
- Register 0: WB_Reg_WriteEn is forced 0 when MEM_Reg_WriteAddr==0.
- dmem_ack outside BUSY is ignored.
- Back-to-back memory ops: after the ack edge, state is IDLE; the next instruction is handled by the IDLE rules and starts a fresh request one cycle later. There is no pipelined overlap.
- Reset mid-access: immediate IDLE, dmem_req=0, and the outstanding access is abandoned. A late ack is ignored.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro:
  - Counter cleared on IDLE→BUSY, incremented each BUSY cycle without ack.
  - When the counter reaches TIMEOUT-1 with no ack, that cycle has stall_req=0.
  - Next edge: state→IDLE, dmem_req=0, WB_* load with WB_Reg_WriteEn=0 (instruction squashed), bus_err=1 for one cycle.
  - An ack in the same cycle as the timeout wins: normal completion, no bus_err.
- Without the macro: no counter, BUSY waits indefinitely, bus_err tied 0.

Test Plan:
- ALU op (Reg_WriteEn=1, addr=5, AluResult=0x1234, no mem) → one edge later WB_Reg_WriteAddr=5, WB_Reg_WriteEn=1, WB_WriteData=0x1234; stall_req never 1.
- Load (ReadEn=1, Mem2R=1, addr=0x103, dest=8), ack after 3 BUSY cycles with rdata=0xCAFEF00D → dmem_addr=0x100, dmem_we=0, stall_req=1 for 4 cycles, then WB_WriteData=0xCAFEF00D, WB_Reg_WriteEn=1.
- Store (WriteEn=1, addr=0x40, data=0xA5A5A5A5, Reg_WriteEn=0), immediate ack → dmem_we=1, dmem_wdata=0xA5A5A5A5, stall_req high exactly 1 cycle, WB_Reg_WriteEn=0.
- Load to dest=0 → WB_Reg_WriteEn=0. Stray ack in IDLE → no state change.
- Assert rst in BUSY → dmem_req, WB_* and stall_req=0 immediately; a subsequent ack is ignored.
- With MEM_TIMEOUT_EN, TIMEOUT=4, no ack → bus_err pulses once after 4 BUSY cycles, WB_Reg_WriteEn=0, state IDLE. Ack arriving on the 4th cycle → normal completion, bus_err=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: req/ack handshake to data memory, stall generation, MEM/WB register.
// Optional macro MEM_TIMEOUT_EN aborts a BUSY access after TIMEOUT cycles and pulses bus_err.
module mem_access_stage #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        MEM_Reg_WriteAddr,
    input  logic              MEM_Reg_WriteEn,
    input  logic [31:0]       MEM_AluResult,
    input  logic              MEM_Mem2R,
    input  logic [ADDR_W-1:0] MEM_DMem_WriteAddr,
    input  logic              MEM_DMem_WriteEn,
    input  logic              MEM_DMem_ReadEn,
    input  logic [31:0]       MEM_DMem_WriteData,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall_req,
    output logic [4:0]        WB_Reg_WriteAddr,
    output logic              WB_Reg_WriteEn,
    output logic [31:0]       WB_WriteData,
    output logic              bus_err
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [4:0]        wb_addr_q, wb_addr_d;
    logic              wb_en_q, wb_en_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              mem_op, wr_en_nz, abort, stall_raw;
    logic              unused_addr_lsb;

    assign mem_op          = MEM_DMem_ReadEn | MEM_DMem_WriteEn;
    assign wr_en_nz        = MEM_Reg_WriteEn && (MEM_Reg_WriteAddr != 5'd0);
    assign unused_addr_lsb = ^MEM_DMem_WriteAddr[1:0];

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q;

    // An ack in the timeout cycle takes priority, so abort requires !dmem_ack.
    assign abort = (state_q == BUSY) && !dmem_ack && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE && mem_op)
            cnt_d = '0;
        else if (state_q == BUSY && !dmem_ack)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= abort;
        end
    end

    assign bus_err = bus_err_q;
`else
    localparam int unused_timeout = TIMEOUT;
    assign abort   = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_op) state_d = BUSY;
            BUSY:    if (dmem_ack || abort) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wb_addr_d = '0;
        wb_en_d   = 1'b0;
        wb_data_d = '0;
        stall_raw = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    stall_raw = 1'b1;
                    req_d     = 1'b1;
                    we_d      = MEM_DMem_WriteEn;
                    addr_d    = {MEM_DMem_WriteAddr[ADDR_W-1:2], 2'b00};
                    wdata_d   = MEM_DMem_WriteData;
                end else begin
                    wb_addr_d = MEM_Reg_WriteAddr;
                    wb_en_d   = wr_en_nz;
                    wb_data_d = MEM_AluResult;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    req_d     = 1'b0;
                    wb_addr_d = MEM_Reg_WriteAddr;
                    wb_en_d   = wr_en_nz;
                    wb_data_d = MEM_Mem2R ? dmem_rdata : MEM_AluResult;
                end else if (abort) begin
                    req_d = 1'b0;
                end else begin
                    stall_raw = 1'b1;
                end
            end
            default: stall_raw = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wb_addr_q <= '0;
            wb_en_q   <= 1'b0;
            wb_data_q <= '0;
        end else begin
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wb_addr_q <= wb_addr_d;
            wb_en_q   <= wb_en_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Reset abandons the access at once, so the stall must drop with it.
    assign stall_req        = stall_raw & ~rst;
    assign dmem_req         = req_q;
    assign dmem_we          = we_q;
    assign dmem_addr        = addr_q;
    assign dmem_wdata       = wdata_q;
    assign WB_Reg_WriteAddr = wb_addr_q;
    assign WB_Reg_WriteEn   = wb_en_q;
    assign WB_WriteData     = wb_data_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table, hand-written corner sequences, random ops vs. memory model.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  MEM_Reg_WriteAddr;
    logic        MEM_Reg_WriteEn;
    logic [31:0] MEM_AluResult;
    logic        MEM_Mem2R;
    logic [31:0] MEM_DMem_WriteAddr;
    logic        MEM_DMem_WriteEn;
    logic        MEM_DMem_ReadEn;
    logic [31:0] MEM_DMem_WriteData;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        stall_req;
    logic [4:0]  WB_Reg_WriteAddr;
    logic        WB_Reg_WriteEn;
    logic [31:0] WB_WriteData;
    logic        bus_err;

    int n_checks = 0;
    int n_pass   = 0;

    mem_access_stage #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .MEM_Reg_WriteAddr(MEM_Reg_WriteAddr), .MEM_Reg_WriteEn(MEM_Reg_WriteEn),
        .MEM_AluResult(MEM_AluResult), .MEM_Mem2R(MEM_Mem2R),
        .MEM_DMem_WriteAddr(MEM_DMem_WriteAddr), .MEM_DMem_WriteEn(MEM_DMem_WriteEn),
        .MEM_DMem_ReadEn(MEM_DMem_ReadEn), .MEM_DMem_WriteData(MEM_DMem_WriteData),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall_req(stall_req),
        .WB_Reg_WriteAddr(WB_Reg_WriteAddr), .WB_Reg_WriteEn(WB_Reg_WriteEn),
        .WB_WriteData(WB_WriteData), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic        mem2r, rd, wr;
        logic [31:0] addr, wdata;
        int          delay;
        logic [31:0] rdata;
        logic        exp_en;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
        int          exp_stalls;
        logic [31:0] exp_daddr;
        logic        exp_dwe;
    } vec_t;

    vec_t vecs[8];
    logic [31:0] mem_model [int];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_nop();
        MEM_Reg_WriteEn = 1'b0; MEM_Reg_WriteAddr = '0; MEM_AluResult = '0; MEM_Mem2R = 1'b0;
        MEM_DMem_ReadEn = 1'b0; MEM_DMem_WriteEn = 1'b0; MEM_DMem_WriteAddr = '0;
        MEM_DMem_WriteData = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    endtask

    function automatic logic [31:0] mem_rd(input int idx);
        if (mem_model.exists(idx)) return mem_model[idx];
        return {idx[15:0], 16'hBEEF};
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the completion edge.
    task automatic do_instr(input vec_t v, input bit chk_full);
        int stalls, busy;
        bit done, seen;
        MEM_Reg_WriteEn = v.en; MEM_Reg_WriteAddr = v.dest; MEM_AluResult = v.alu;
        MEM_Mem2R = v.mem2r; MEM_DMem_ReadEn = v.rd; MEM_DMem_WriteEn = v.wr;
        MEM_DMem_WriteAddr = v.addr; MEM_DMem_WriteData = v.wdata; dmem_ack = 1'b0;
        stalls = 0; busy = 0; done = 0; seen = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            if (dmem_req) begin
                if (!seen) begin
                    seen = 1;
                    chk("dmem_addr", dmem_addr, v.exp_daddr);
                    chk("dmem_we", {31'b0, dmem_we}, {31'b0, v.exp_dwe});
                    if (v.exp_dwe) chk("dmem_wdata", dmem_wdata, v.wdata);
                end
                dmem_ack   = (busy == v.delay);
                dmem_rdata = dmem_ack ? v.rdata : $urandom;
                busy++;
            end
            if (c > 0) chk("wb_bubble", {31'b0, WB_Reg_WriteEn}, 32'd0);
            #1;
            if (stall_req) stalls++;
            else done = 1;
            @(posedge clk); #1;
            dmem_ack = 1'b0;
        end
        if (!done) chk("instr_done", 32'd0, 32'd1);
        chk("stall_cycles", stalls, v.exp_stalls);
        chk("saw_request", {31'b0, seen}, {31'b0, (v.rd | v.wr)});
        chk("wb_en", {31'b0, WB_Reg_WriteEn}, {31'b0, v.exp_en});
        chk("dmem_req_done", {31'b0, dmem_req}, 32'd0);
        if (chk_full) begin
            chk("wb_addr", {27'b0, WB_Reg_WriteAddr}, {27'b0, v.exp_waddr});
            chk("wb_data", WB_WriteData, v.exp_wdata);
        end
    endtask

    initial begin
        vec_t v;
        int   nrand;
        //          en dest  alu        m2r rd wr addr      wdata        dly rdata         xen xaddr xdata       xst xdaddr    xwe
        vecs[0] = '{1, 5'd5, 32'h1234,  0,  0, 0, 32'h0,    32'h0,       0, 32'h0,        1,  5'd5, 32'h1234,   0,  32'h0,    0};
        vecs[1] = '{1, 5'd8, 32'h55,    1,  1, 0, 32'h103,  32'h0,       3, 32'hCAFEF00D, 1,  5'd8, 32'hCAFEF00D, 4, 32'h100,  0};
        vecs[2] = '{0, 5'd3, 32'h77,    0,  0, 1, 32'h40,   32'hA5A5A5A5, 0, 32'h0,       0,  5'd3, 32'h77,     1,  32'h40,   1};
        vecs[3] = '{1, 5'd0, 32'h0,     1,  1, 0, 32'h8,    32'h0,       1, 32'h11112222, 0,  5'd0, 32'h11112222, 2, 32'h8,    0};
        vecs[4] = '{1, 5'd0, 32'h99,    0,  0, 0, 32'h0,    32'h0,       0, 32'h0,        0,  5'd0, 32'h99,     0,  32'h0,    0};
        vecs[5] = '{1, 5'd9, 32'hABC,   0,  1, 1, 32'h1FF,  32'h600D,    2, 32'h3333,     1,  5'd9, 32'hABC,    3,  32'h1FC,  1};
        vecs[6] = '{1, 5'd31, 32'hF0F0, 1,  0, 0, 32'h7,    32'h0,       0, 32'h0,        1,  5'd31, 32'hF0F0,  0,  32'h0,    0};
        vecs[7] = '{1, 5'd2, 32'h2222,  0,  1, 0, 32'h22,   32'h0,       0, 32'h4444,     1,  5'd2, 32'h2222,   1,  32'h20,   0};

        set_nop();
        rst = 1'b1;
        MEM_Reg_WriteEn = 1'b1; MEM_Reg_WriteAddr = 5'd7; MEM_AluResult = 32'h77;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_wb_en", {31'b0, WB_Reg_WriteEn}, 32'd0);
        chk("rst_wb_data", WB_WriteData, 32'd0);
        chk("rst_stall", {31'b0, stall_req}, 32'd0);
        chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
        set_nop();
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) do_instr(vecs[i], 1'b1);

        // Stray ack in IDLE with an ALU op
        set_nop();
        MEM_Reg_WriteEn = 1'b1; MEM_Reg_WriteAddr = 5'd4; MEM_AluResult = 32'h4444;
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADDEAD;
        #1;
        chk("stray_ack_stall", {31'b0, stall_req}, 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("stray_ack_req", {31'b0, dmem_req}, 32'd0);
        chk("stray_ack_wb", WB_WriteData, 32'h4444);

        // Reset in the middle of an outstanding load, then a late ack
        set_nop();
        MEM_Reg_WriteEn = 1'b1; MEM_Reg_WriteAddr = 5'd6; MEM_Mem2R = 1'b1;
        MEM_DMem_ReadEn = 1'b1; MEM_DMem_WriteAddr = 32'h80;
        @(posedge clk); #1;
        chk("mid_busy_req", {31'b0, dmem_req}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_req", {31'b0, dmem_req}, 32'd0);
        chk("mid_rst_wb_en", {31'b0, WB_Reg_WriteEn}, 32'd0);
        chk("mid_rst_stall", {31'b0, stall_req}, 32'd0);
        set_nop();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
        #1;
        chk("late_ack_stall", {31'b0, stall_req}, 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("late_ack_req", {31'b0, dmem_req}, 32'd0);
        chk("late_ack_wb_en", {31'b0, WB_Reg_WriteEn}, 32'd0);

`ifdef MEM_TIMEOUT_EN
        // No ack: aborted after 4 BUSY cycles, instruction squashed
        v = '{1, 5'd10, 32'h10, 1, 1, 0, 32'h200, 32'h0, 100, 32'h0, 0, 5'd0, 32'h0, 4, 32'h200, 0};
        do_instr(v, 1'b0);
        chk("timeout_bus_err", {31'b0, bus_err}, 32'd1);
        set_nop();
        @(posedge clk); #1;
        chk("timeout_bus_err_pulse", {31'b0, bus_err}, 32'd0);
        // Ack on the 4th BUSY cycle wins over the timeout
        v = '{1, 5'd11, 32'h11, 1, 1, 0, 32'h204, 32'h0, 3, 32'h0BADF00D, 1, 5'd11, 32'h0BADF00D, 4, 32'h204, 0};
        do_instr(v, 1'b1);
        chk("late_ack_no_bus_err", {31'b0, bus_err}, 32'd0);
`endif

        // Random instruction stream against a word-addressed memory model
        nrand = 40;
        for (int i = 0; i < nrand; i++) begin
            int kind, idx;
            kind = $urandom_range(0, 2);
            idx  = $urandom_range(0, 15);
            v.en    = $urandom_range(0, 1);
            v.dest  = 5'($urandom_range(0, 31));
            v.alu   = $urandom;
            v.rd    = (kind == 1);
            v.wr    = (kind == 2);
            v.mem2r = (kind == 1) ? 1'b1 : ((kind == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
            v.addr  = (idx * 4) + $urandom_range(0, 3);
            v.wdata = $urandom;
`ifdef MEM_TIMEOUT_EN
            v.delay = $urandom_range(0, 3);
`else
            v.delay = $urandom_range(0, 5);
`endif
            v.rdata      = mem_rd(idx);
            v.exp_en     = v.en && (v.dest != 5'd0);
            v.exp_waddr  = v.dest;
            v.exp_wdata  = ((v.rd || v.wr) && v.mem2r) ? v.rdata : v.alu;
            v.exp_stalls = (v.rd || v.wr) ? v.delay + 1 : 0;
            v.exp_daddr  = idx * 4;
            v.exp_dwe    = v.wr;
            do_instr(v, 1'b1);
            chk("rand_bus_err", {31'b0, bus_err}, 32'd0);
            if (v.wr) mem_model[idx] = v.wdata;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
